line_word_buf: RTL
==================

LINE_WORD_BUF -- requirements
Module: line_word_buf

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of one cache word.
REQ-002 SHALL have parameter WORDS, default 8, words per line; power of two, >= 2.
REQ-003 SHALL derive SEL_W = log2(WORDS), default 3; not overridable.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 fill_start  in  1  request line refill.
REQ-007 fill_addr  in  SEL_W  critical word index, first beat of refill.
REQ-008 mem_valid  in  1  refill beat present on mem_data.
REQ-009 mem_data  in  DATA_WIDTH  refill beat data.
REQ-010 mem_ready  out  1  buffer accepts a beat this cycle.
REQ-011 fill_done  out  1  one-cycle pulse, last beat accepted.
REQ-012 flush  in  1  invalidate line, abort any refill.
REQ-013 rd_en  in  1  word read request.
REQ-014 rd_sel  in  SEL_W  word index to read.
REQ-015 rd_data  out  DATA_WIDTH  registered read data.
REQ-016 rd_valid  out  1  rd_data holds a hit for the previous cycle's request.
REQ-017 busy  out  1  high while in FILL.
REQ-018 line_valid  out  1  all WORDS words valid.

Function
REQ-019 SHALL implement FSM with states IDLE and FILL.
REQ-020 IDLE -> FILL on fill_start & !flush; capture fill_addr as base; clear beat counter and all per-word valid bits.
REQ-021 In FILL: mem_ready = 1; a beat is accepted on mem_valid & mem_ready.
REQ-022 Accepted beat k (0..WORDS-1) SHALL be written to word (base + k) mod WORDS and set that word's valid bit; index wraps modulo WORDS.
REQ-023 Accepting beat WORDS-1 SHALL pulse fill_done for that same cycle, set line_valid next cycle, and return to IDLE.
REQ-024 mem_valid with mem_ready low SHALL be ignored; there is no buffering of unaccepted beats.
REQ-025 fill_start during FILL SHALL be ignored.
REQ-026 flush in any state SHALL clear all valid bits and line_valid and go to IDLE next cycle; flush has priority over fill_start and over a same-cycle beat (beat discarded, no fill_done).
REQ-027 Read latency is one cycle: rd_en at edge t -> rd_data/rd_valid updated at edge t.
REQ-028 rd_valid = 1 iff rd_en was high and word rd_sel was valid, or was being written by an accepted beat, in that cycle.
REQ-029 Read of the word written in the same cycle SHALL return mem_data (bypass), not the stale value.
REQ-030 Read of a non-valid word SHALL give rd_valid = 0; rd_data is then don't-care, but held at its previous value.
REQ-031 rd_en low SHALL give rd_valid = 0 next cycle, with rd_data held.
REQ-032 Reads are permitted in both states; the critical word is therefore readable one cycle after its beat.
REQ-033 Read concurrent with flush SHALL return rd_valid = 0.
REQ-034 busy = (state == FILL); line_valid = AND of all valid bits.

Reset
REQ-035 rst high SHALL immediately force state IDLE, valid bits 0, beat counter 0, mem_ready 0, fill_done 0, busy 0, line_valid 0, rd_valid 0, rd_data 0.
REQ-036 rst asserted mid-refill SHALL abort it, with no fill_done; word storage contents need not be cleared.

Verification
REQ-037 fill_start, fill_addr=5, 8 back-to-back beats 0xA0..0xA7 -> words 5,6,7,0,1,2,3,4 = 0xA0..0xA7; fill_done on 8th beat; line_valid next cycle.
REQ-038 rd_en, rd_sel=5 in the same cycle as beat 0 (0xA0) -> next cycle rd_data=0xA0, rd_valid=1; rd_sel=6 at that time -> rd_valid=0.
REQ-039 Beats with mem_valid gaps (1 on, 2 off, repeated) -> only 8 accepted; fill_done exactly once; busy high throughout.
REQ-040 flush after 3 beats, same cycle as beat 4 -> IDLE next cycle, line_valid=0, no fill_done; read of word 5 -> rd_valid=0.
REQ-041 rst pulse mid-FILL, then a fresh fill_addr=0 refill -> all outputs 0 during reset; the new refill completes normally at words 0..7.
REQ-042 WORDS=4, DATA_WIDTH=64, fill_addr=3 -> word order 3,0,1,2; wrap-around is correct.

Source files
------------

// File: rtl/line_word_buf.sv
// rtl/line_word_buf.sv - cache line refill buffer with critical-word-first fill and bypassed reads
module line_word_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int WORDS      = 8,
    localparam int SEL_W     = $clog2(WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fill_start,
    input  logic [SEL_W-1:0]      fill_addr,
    input  logic                  mem_valid,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_ready,
    output logic                  fill_done,
    input  logic                  flush,
    input  logic                  rd_en,
    input  logic [SEL_W-1:0]      rd_sel,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  line_valid
);

    typedef enum logic {IDLE, FILL} state_t;

    state_t                state, state_nxt;
    logic [SEL_W-1:0]      base;
    logic [SEL_W-1:0]      beat_cnt;
    logic [SEL_W-1:0]      wr_idx;
    logic [WORDS-1:0]      valid;
    logic [DATA_WIDTH-1:0] store [WORDS];
    logic                  start;
    logic                  accept;
    logic                  hit_bypass;
    logic                  hit;

    // Beats land at base + k; the index wraps because WORDS is a power of two.
    assign wr_idx     = base + beat_cnt;
    assign busy       = (state == FILL);
    assign line_valid = &valid;
    assign hit_bypass = accept && (wr_idx == rd_sel);
    assign hit        = rd_en && !flush && (valid[rd_sel] || hit_bypass);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and handshake outputs; flush beats fill_start and any same-cycle beat.
    always_comb begin
        state_nxt = state;
        mem_ready = 1'b0;
        accept    = 1'b0;
        fill_done = 1'b0;
        start     = 1'b0;
        case (state)
            IDLE: begin
                if (fill_start && !flush) begin
                    state_nxt = FILL;
                    start     = 1'b1;
                end
            end
            FILL: begin
                mem_ready = 1'b1;
                if (flush) begin
                    state_nxt = IDLE;
                end else if (mem_valid) begin
                    accept = 1'b1;
                    if (beat_cnt == SEL_W'(WORDS - 1)) begin
                        fill_done = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Refill bookkeeping: base index, beat counter and per-word valid bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base     <= '0;
            beat_cnt <= '0;
            valid    <= '0;
        end else if (flush) begin
            beat_cnt <= '0;
            valid    <= '0;
        end else if (start) begin
            base     <= fill_addr;
            beat_cnt <= '0;
            valid    <= '0;
        end else if (accept) begin
            valid[wr_idx] <= 1'b1;
            beat_cnt      <= beat_cnt + SEL_W'(1);
        end
    end

    // Word storage; contents survive reset since valid bits gate every read.
    always_ff @(posedge clk) begin
        if (accept) store[wr_idx] <= mem_data;
    end

    // Registered read port; a word written this cycle is forwarded from mem_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= hit;
            if (hit) rd_data <= hit_bypass ? mem_data : store[rd_sel];
        end
    end

endmodule
